// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: classifier FSM states and default frame geometry.
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_NUM_OUTPUTS = 10;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  typedef enum logic [0:0] {
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare/update cell: folds one incoming score into the running best (and runner-up
// when ARGMAX_TOP2_EN is defined). Beat index 0 restarts the tracking for a new frame.
module argmax_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic [DATA_WIDTH-1:0] best_score,
  input  logic [IDX_WIDTH-1:0]  best_idx,
  output logic [DATA_WIDTH-1:0] next_score,
  output logic [IDX_WIDTH-1:0]  next_idx
`ifdef ARGMAX_TOP2_EN
  ,
  input  logic [DATA_WIDTH-1:0] best_score2,
  input  logic [IDX_WIDTH-1:0]  best_idx2,
  output logic [DATA_WIDTH-1:0] next_score2,
  output logic [IDX_WIDTH-1:0]  next_idx2
`endif
);

  logic first;
  assign first = (in_idx == '0);

  // Strict greater-than so that ties keep the lower class index.
  always_comb begin
    next_score = best_score;
    next_idx   = best_idx;
    if (first || (in_data > best_score)) begin
      next_score = in_data;
      next_idx   = in_idx;
    end
  end

`ifdef ARGMAX_TOP2_EN
  // A new top demotes the old top; beat 1 always seeds the runner-up, ties with the top land here.
  always_comb begin
    next_score2 = best_score2;
    next_idx2   = best_idx2;
    if (first) begin
      next_score2 = '0;
      next_idx2   = '0;
    end else if (in_data > best_score) begin
      next_score2 = best_score;
      next_idx2   = best_idx;
    end else if ((in_idx == IDX_WIDTH'(1)) || (in_data > best_score2)) begin
      next_score2 = in_data;
      next_idx2   = in_idx;
    end
  end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Streaming top-1 classifier: tracks the running maximum of one score frame and holds the result
// on a valid/ready output. Optional runner-up/margin outputs are enabled by ARGMAX_TOP2_EN.
module argmax_classifier
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int NUM_OUTPUTS = DEFAULT_NUM_OUTPUTS,
  parameter int IDX_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_class,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic                  out_err
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_WIDTH-1:0]  out_class2,
  output logic [DATA_WIDTH-1:0] out_score2,
  output logic [DATA_WIDTH-1:0] out_margin
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUTPUTS - 1);

  state_e                state;
  logic                  live;
  logic [IDX_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] best_score, next_score;
  logic [IDX_WIDTH-1:0]  best_idx, next_idx;
  logic                  err;
  logic                  accept, at_last, frame_end;

  // live keeps in_ready low while reset is held, without a path from any input.
  assign in_ready  = live && (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_class = best_idx;
  assign out_score = best_score;
  assign out_err   = err;

  assign accept    = in_valid && in_ready;
  assign at_last   = (cnt == LAST_IDX);
  assign frame_end = in_last || at_last;

`ifdef ARGMAX_TOP2_EN
  logic [DATA_WIDTH-1:0] best_score2, next_score2;
  logic [IDX_WIDTH-1:0]  best_idx2, next_idx2;

  assign out_class2 = best_idx2;
  assign out_score2 = best_score2;
  assign out_margin = best_score - best_score2;
`endif

  argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_cmp (
    .in_data     (in_data),
    .in_idx      (cnt),
    .best_score  (best_score),
    .best_idx    (best_idx),
    .next_score  (next_score),
    .next_idx    (next_idx)
`ifdef ARGMAX_TOP2_EN
    ,
    .best_score2 (best_score2),
    .best_idx2   (best_idx2),
    .next_score2 (next_score2),
    .next_idx2   (next_idx2)
`endif
  );

  // The frame closes on whichever comes first: in_last or the final expected beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      live       <= 1'b0;
      cnt        <= '0;
      best_score <= '0;
      best_idx   <= '0;
      err        <= 1'b0;
    end else begin
      live <= 1'b1;
      if (state == ACCUM) begin
        if (accept) begin
          best_score <= next_score;
          best_idx   <= next_idx;
          cnt        <= cnt + IDX_WIDTH'(1);
          if (frame_end) begin
            state <= DONE;
            err   <= (in_last != at_last);
          end
        end
      end else if (out_ready) begin
        state <= ACCUM;
        cnt   <= '0;
        err   <= 1'b0;
      end
    end
  end

`ifdef ARGMAX_TOP2_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_score2 <= '0;
      best_idx2   <= '0;
    end else if (accept) begin
      best_score2 <= next_score2;
      best_idx2   <= next_idx2;
    end
  end
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed frames plus randomized frames against a
// reference model of the frame rules. Runner-up checks are included when ARGMAX_TOP2_EN is defined.
module tb_argmax_classifier;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_class;
  logic [DW-1:0] out_score;
  logic          out_err;
`ifdef ARGMAX_TOP2_EN
  logic [IW-1:0] out_class2;
  logic [DW-1:0] out_score2;
  logic [DW-1:0] out_margin;
`endif

  typedef struct packed {
    logic [IW-1:0] cls;
    logic [DW-1:0] score;
    logic          err;
    logic [IW-1:0] cls2;
    logic [DW-1:0] score2;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   randomReady = 1'b0;

  argmax_classifier #(
    .DATA_WIDTH  (DW),
    .NUM_OUTPUTS (N),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_score  (out_score),
    .out_err    (out_err)
`ifdef ARGMAX_TOP2_EN
    ,
    .out_class2 (out_class2),
    .out_score2 (out_score2),
    .out_margin (out_margin)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Index of the beat that closes the frame: first in_last, or the last expected beat.
  function automatic int frameEnd(input bit lasts[N]);
    for (int k = 0; k < N; k++)
      if (lasts[k] || k == N - 1) return k;
    return N - 1;
  endfunction

  // Reference: top = highest value (earliest on ties); runner-up = highest of the remaining beats
  // (earliest on ties); error when the closing beat disagrees with the in_last flag.
  function automatic exp_t refModel(input int vals[N], input bit lasts[N]);
    exp_t r;
    int   e, topV, topI, secV, secI;
    e = frameEnd(lasts);
    topV = -1; topI = 0;
    for (int k = 0; k <= e; k++)
      if (vals[k] > topV) begin topV = vals[k]; topI = k; end
    secV = -1; secI = 0;
    for (int k = 0; k <= e; k++)
      if (k != topI && vals[k] > secV) begin secV = vals[k]; secI = k; end
    if (secV < 0) begin secV = 0; secI = 0; end
    r.cls    = IW'(topI);
    r.score  = DW'(topV);
    r.err    = (lasts[e] != (e == N - 1));
    r.cls2   = IW'(secI);
    r.score2 = DW'(secV);
    return r;
  endfunction

  task automatic applyStimulus(input int vals[N], input bit lasts[N], input int gapPct,
                               input bit expectResult, input int stopAfter);
    int e;
    bit accepted;
    e = frameEnd(lasts);
    if (stopAfter < e) e = stopAfter;
    if (expectResult) expQ.push_back(refModel(vals, lasts));
    for (int k = 0; k <= e; k++) begin
      while ($urandom_range(0, 99) < gapPct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(vals[k]);
      in_last  = lasts[k];
      accepted = 1'b0;
      for (int c = 0; c < 200 && !accepted; c++) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk); #1;
      end
      if (!accepted) begin
        checks++;
        errors++;
        $display("[TB] FAIL beatAccept: beat %0d not accepted within 200 cycles, in_ready=%0b", k, in_ready);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 500 && expQ.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("drain", expQ.size(), 0);
  endtask

  // Monitor: pops one expectation per output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResult: class=%0d score=%0h with empty scoreboard", out_class, out_score);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_class", out_class, e.cls);
        checkOutput("out_score", out_score, e.score);
        checkOutput("out_err", out_err, e.err);
`ifdef ARGMAX_TOP2_EN
        checkOutput("out_class2", out_class2, e.cls2);
        checkOutput("out_score2", out_score2, e.score2);
        checkOutput("out_margin", out_margin, DW'(e.score - e.score2));
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int vals[N];
    bit lasts[N];
    int init1[N] = '{3, 9, 1, 7, 9, 2, 0, 5, 4, 6};

    // Reset state while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_class", out_class, 0);
    checkOutput("rst_out_score", out_score, 0);
    checkOutput("rst_out_err", out_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Reference frame with backpressure held for 20 cycles.
    $display("[TB] directed frame 3,9,1,7,9,2,0,5,4,6");
    foreach (vals[k]) begin vals[k] = init1[k]; lasts[k] = 1'b0; end
    lasts[9] = 1'b1;
    out_ready = 1'b0;
    applyStimulus(vals, lasts, 0, 1'b1, N);
    checkOutput("latency_out_valid", out_valid, 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_out_class", out_class, 1);
      checkOutput("hold_out_score", out_score, 9);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_out_valid", out_valid, 0);
    checkOutput("release_in_ready", in_ready, 1);

    // Short frame: in_last on beat 4.
    $display("[TB] short frame 10..50");
    foreach (vals[k]) begin vals[k] = (k < 5) ? 10 * (k + 1) : 0; lasts[k] = (k == 4); end
    applyStimulus(vals, lasts, 0, 1'b1, N);
    waitDrain();

    // Full frame with in_last missing on the final beat.
    $display("[TB] missing in_last frame");
    foreach (vals[k]) begin vals[k] = $urandom_range(0, 65535); lasts[k] = 1'b0; end
    applyStimulus(vals, lasts, 0, 1'b1, N);
    waitDrain();

    // Decreasing frame with random valid gaps.
    $display("[TB] decreasing frame with gaps");
    foreach (vals[k]) begin vals[k] = 100 - k; lasts[k] = (k == N - 1); end
    applyStimulus(vals, lasts, 40, 1'b1, N);
    waitDrain();

    // Abort a frame with reset after beat 5, then run a clean frame.
    $display("[TB] reset mid-frame");
    foreach (vals[k]) begin vals[k] = (k == 3) ? 16'hFFFF : 1000 + k; lasts[k] = 1'b0; end
    applyStimulus(vals, lasts, 0, 1'b0, 5);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_score", out_score, 0);
    checkOutput("midrst_out_class", out_class, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (vals[k]) begin vals[k] = (k == 8) ? 16'hFFFF : 100 * k; lasts[k] = (k == N - 1); end
    applyStimulus(vals, lasts, 0, 1'b1, N);
    waitDrain();

    // Randomized frames: mixed frame endings, narrow value ranges for ties, random backpressure.
    $display("[TB] random frames");
    randomReady = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int mode;
      mode = $urandom_range(0, 2);
      foreach (vals[k]) begin
        vals[k]  = (f % 2 == 1) ? $urandom_range(0, 7) : $urandom_range(0, 65535);
        lasts[k] = 1'b0;
      end
      if (mode == 0) lasts[N - 1] = 1'b1;
      else if (mode == 1) lasts[$urandom_range(0, N - 1)] = 1'b1;
      applyStimulus(vals, lasts, 25, 1'b1, N);
    end
    waitDrain();
    randomReady = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
